// File: rtl/cpu_run_monitor_if.sv
// Trace drain port of cpu_run_monitor: head-of-FIFO entry, occupancy and pop handshake.
// The monitor drives the master side; a consumer (software bridge or bench) uses slave.
interface cpu_run_monitor_if #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TRACE_DEPTH = 16
);
  localparam int unsigned EntryW = ADDR_W + 2 * DATA_W;
  localparam int unsigned LevelW = $clog2(TRACE_DEPTH) + 1;

  logic              trace_valid;
  logic [EntryW-1:0] trace_data;
  logic              trace_ready;
  logic [LevelW-1:0] trace_level;

  modport master (
    output trace_valid,
    output trace_data,
    output trace_level,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_data,
    input  trace_level,
    output trace_ready
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller beside the CPU: bounds a run by cycle budget, detects halt opcode or PC stall,
// and records every PC change into a first-word-fall-through trace FIFO.
module cpu_run_monitor #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned MAX_CYCLES  = 300,
  parameter int unsigned STALL_LIMIT = 4,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] inst,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] currentPC,
  input  logic [DATA_W-1:0] res,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count,
  output logic              overflow,
  cpu_run_monitor_if.master trace
);

  localparam int unsigned EntryW = ADDR_W + 2 * DATA_W;
  localparam int unsigned LevelW = $clog2(TRACE_DEPTH) + 1;
  localparam int unsigned PtrW   = $clog2(TRACE_DEPTH);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                overflow_q, overflow_d;
  logic [StallW-1:0]   stall_q, stall_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                running_q, done_q;

  logic [EntryW-1:0]   mem_q [TRACE_DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [LevelW-1:0]   level_q, level_d;

  logic push_req, pop, full, flush, wr_en;

  assign flush    = start && (state_q != StRun);
  assign push_req = (state_q == StRun) && (first_q || (currentPC != pc_q));
  assign full     = (level_q == LevelW'(TRACE_DEPTH));
  assign pop      = trace.trace_ready && (level_q != '0) && !flush;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en    = push_req && (!full || pop);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cycle_d    = cycle_q;
    retired_d  = retired_q;
    overflow_d = overflow_q;
    stall_d    = stall_q;
    first_d    = first_q;
    pc_d       = pc_q;
    unique case (state_q)
      StIdle, StHalted, StTimeout: begin
        if (start) begin
          state_d    = StRun;
          cause_d    = 2'b00;
          cycle_d    = '0;
          retired_d  = '0;
          overflow_d = 1'b0;
          stall_d    = '0;
          first_d    = 1'b1;
        end
      end
      StRun: begin
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
        if (push_req) begin
          if (retired_q != '1) retired_d = retired_q + 1'b1;
          if (full && !pop) overflow_d = 1'b1;
          stall_d = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
        pc_d    = currentPC;
        first_d = 1'b0;
        if (opcode == HALT_OPCODE) begin
          state_d = StHalted;
          cause_d = 2'b01;
        end else if (!push_req && (stall_q == StallW'(STALL_LIMIT - 1))) begin
          state_d = StHalted;
          cause_d = 2'b10;
        end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = StTimeout;
          cause_d = 2'b11;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      level_d = level_q + LevelW'(wr_en) - LevelW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cause_q    <= 2'b00;
      cycle_q    <= '0;
      retired_q  <= '0;
      overflow_q <= 1'b0;
      stall_q    <= '0;
      first_q    <= 1'b0;
      pc_q       <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
      first_q    <= first_d;
      pc_q       <= pc_d;
      running_q  <= (state_d == StRun);
      done_q     <= (state_d == StHalted) || (state_d == StTimeout);
      level_q    <= level_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_en) wptr_q <= wptr_q + 1'b1;
        if (pop)   rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: level_q gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {currentPC, inst, res};
  end

  assign running           = running_q;
  assign done              = done_q;
  assign halt_cause        = cause_q;
  assign cycle_count       = cycle_q;
  assign retired_count     = retired_q;
  assign overflow          = overflow_q;
  assign trace.trace_valid = (level_q != '0);
  assign trace.trace_data  = mem_q[rptr_q];
  assign trace.trace_level = level_q;

endmodule
